// File: rtl/load_store_queue_pkg.sv
// Shared types for the in-order load/store queue.
// Entry layout, pointer type and RV32 memory func3 encodings.
package load_store_queue_pkg;

   localparam int LSQ_DEPTH  = 8;
   localparam int LSQ_ROB_W  = 5;
   localparam int LSQ_PREG_W = 7;
   localparam int LSQ_PTR_W  = $clog2(LSQ_DEPTH) + 1;

   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;

   typedef logic [LSQ_PTR_W-1:0] lsq_ptr_t;

   typedef struct packed {
      logic                  valid;
      logic                  is_store;
      logic [2:0]            func3;
      logic [LSQ_ROB_W-1:0]  rob_tag;
      logic [LSQ_PREG_W-1:0] pd;
      logic [31:0]           addr;
      logic [31:0]           data;
      logic                  addr_rdy;
      logic                  committed;
      logic                  issued;
   } lsq_entry_t;

   // Word-granular overlap: any sub-word access inside one word conflicts.
   function automatic logic word_hit(input logic [31:0] a, input logic [31:0] b);
      return a[31:2] == b[31:2];
   endfunction

endpackage

// File: rtl/load_store_queue_if.sv
// Dispatch, FU-mem, ROB and data-memory signals of the load/store queue.
// slave is the queue side, master the surrounding pipeline side.
interface load_store_queue_if
   import load_store_queue_pkg::*;
#(
   parameter int DEPTH = LSQ_DEPTH
) ();

   localparam int CW = $clog2(DEPTH) + 1;

   logic                  alloc_valid;
   logic                  alloc_store;
   logic [2:0]            alloc_func3;
   logic [LSQ_ROB_W-1:0]  alloc_rob_tag;
   logic [LSQ_PREG_W-1:0] alloc_pd;
   logic                  alloc_ready;
   logic                  addr_valid;
   logic [LSQ_ROB_W-1:0]  addr_rob_tag;
   logic [31:0]           addr;
   logic [31:0]           addr_st_data;
   logic                  commit_valid;
   logic [LSQ_ROB_W-1:0]  commit_rob_tag;
   logic                  flush;
   logic                  store_wb;
   logic [31:0]           st_addr;
   logic [31:0]           st_data;
   logic                  st_sw_sh;
   logic                  load_mem;
   logic [31:0]           ld_addr;
   logic [2:0]            ld_func3;
   logic [LSQ_PREG_W-1:0] ld_pd;
   logic [LSQ_ROB_W-1:0]  ld_rob_tag;
   logic [CW-1:0]         count;

   modport slave (
      input  alloc_valid, alloc_store, alloc_func3, alloc_rob_tag, alloc_pd,
      input  addr_valid, addr_rob_tag, addr, addr_st_data,
      input  commit_valid, commit_rob_tag, flush,
      output alloc_ready, store_wb, st_addr, st_data, st_sw_sh,
      output load_mem, ld_addr, ld_func3, ld_pd, ld_rob_tag, count
   );

   modport master (
      output alloc_valid, alloc_store, alloc_func3, alloc_rob_tag, alloc_pd,
      output addr_valid, addr_rob_tag, addr, addr_st_data,
      output commit_valid, commit_rob_tag, flush,
      input  alloc_ready, store_wb, st_addr, st_data, st_sw_sh,
      input  load_mem, ld_addr, ld_func3, ld_pd, ld_rob_tag, count
   );

endinterface

// File: rtl/load_store_queue_lsq_load_picker.sv
// Age-ordered scan from head for the oldest load that may issue:
// every older store must have a known address in a different word.
module lsq_load_picker
   import load_store_queue_pkg::*;
#(
   parameter int DEPTH = LSQ_DEPTH
) (
   input  lsq_entry_t                i_q [DEPTH],
   input  logic [$clog2(DEPTH):0]    i_head,
   input  logic [$clog2(DEPTH):0]    i_count,
   output logic                      o_eligible,
   output logic [$clog2(DEPTH)-1:0]  o_idx
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   always_comb begin
      logic [IW-1:0] jdx;
      logic [IW-1:0] kdx;
      logic          cand;
      logic          clear;
      o_eligible = 1'b0;
      o_idx      = '0;
      jdx        = '0;
      kdx        = '0;
      cand       = 1'b0;
      clear      = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
         jdx   = i_head[IW-1:0] + IW'(j);
         cand  = (PW'(j) < i_count) && i_q[jdx].valid && !i_q[jdx].is_store
               && i_q[jdx].addr_rdy && !i_q[jdx].issued;
         clear = 1'b1;
         for (int k = 0; k < DEPTH; k++) begin
            kdx = i_head[IW-1:0] + IW'(k);
            if (k < j && i_q[kdx].valid && i_q[kdx].is_store
                && (!i_q[kdx].addr_rdy
                    || word_hit(i_q[kdx].addr, i_q[jdx].addr)))
               clear = 1'b0;
         end
         if (!o_eligible && cand && clear) begin
            o_eligible = 1'b1;
            o_idx      = jdx;
         end
      end
   end

endmodule

// File: rtl/load_store_queue.sv
// In-order circular load/store queue: stores drain after commit,
// loads issue once all older stores are known and non-overlapping.
module load_store_queue
   import load_store_queue_pkg::*;
#(
   parameter int DEPTH = LSQ_DEPTH
) (
   input logic               clk,
   input logic               reset_n,
   load_store_queue_if.slave lsq
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   lsq_entry_t    r_q [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;

   logic [PW-1:0] w_count;
   logic          w_empty;
   logic          w_full;
   lsq_entry_t    w_h;
   lsq_entry_t    w_ld_e;
   lsq_entry_t    w_new;
   logic          w_drain;
   logic          w_ld_pop;
   logic          w_pop;
   logic          w_ld_ok;
   logic [IW-1:0] w_ld_idx;
   logic          w_issue;
   logic          w_alloc;
   logic [PW-1:0] w_ncommit;
   logic [DEPTH-1:0] w_keep;

   assign w_count = r_tail - r_head;
   assign w_empty = (r_head == r_tail);
   assign w_full  = (r_head[IW-1:0] == r_tail[IW-1:0])
                  && (r_head[IW] != r_tail[IW]);

   assign lsq.alloc_ready = !w_full;
   assign lsq.count       = w_count;

   assign w_h      = r_q[r_head[IW-1:0]];
   assign w_ld_e   = r_q[w_ld_idx];
   assign w_drain  = !w_empty && w_h.valid && w_h.is_store
                   && w_h.committed && w_h.addr_rdy;
   // A flush discards an issued head load, so it must not also pop.
   assign w_ld_pop = !w_empty && w_h.valid && !w_h.is_store
                   && w_h.issued && !lsq.flush;
   assign w_pop    = w_drain || w_ld_pop;
   assign w_issue  = w_ld_ok && !w_drain && !lsq.flush;
   assign w_alloc  = lsq.alloc_valid && !w_full && !lsq.flush;

   always_comb begin
      w_new           = '0;
      w_new.valid     = 1'b1;
      w_new.is_store  = lsq.alloc_store;
      w_new.func3     = lsq.alloc_func3;
      w_new.rob_tag   = lsq.alloc_rob_tag;
      w_new.pd        = lsq.alloc_pd;
   end

   // Committed stores form a contiguous prefix from head; they survive a flush.
   always_comb begin
      logic          run;
      logic [IW-1:0] idx;
      logic [IW-1:0] age;
      run       = 1'b1;
      idx       = '0;
      age       = '0;
      w_ncommit = '0;
      w_keep    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = r_head[IW-1:0] + IW'(i);
         if (run && PW'(i) < w_count && r_q[idx].is_store && r_q[idx].committed)
            w_ncommit = w_ncommit + PW'(1);
         else
            run = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         age       = IW'(i) - r_head[IW-1:0];
         w_keep[i] = ({1'b0, age} < w_ncommit);
      end
   end

   lsq_load_picker #(
      .DEPTH      (DEPTH)
   ) u_picker (
      .i_q        (r_q),
      .i_head     (r_head),
      .i_count    (w_count),
      .o_eligible (w_ld_ok),
      .o_idx      (w_ld_idx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
         r_head         <= '0;
         r_tail         <= '0;
         lsq.store_wb   <= 1'b0;
         lsq.st_addr    <= '0;
         lsq.st_data    <= '0;
         lsq.st_sw_sh   <= 1'b0;
         lsq.load_mem   <= 1'b0;
         lsq.ld_addr    <= '0;
         lsq.ld_func3   <= '0;
         lsq.ld_pd      <= '0;
         lsq.ld_rob_tag <= '0;
      end else begin
         lsq.store_wb <= w_drain;
         lsq.load_mem <= w_issue;
         if (w_drain) begin
            lsq.st_addr  <= w_h.addr;
            lsq.st_data  <= w_h.data;
            lsq.st_sw_sh <= (w_h.func3 == F3_SH);
         end
         if (w_issue) begin
            lsq.ld_addr          <= w_ld_e.addr;
            lsq.ld_func3         <= w_ld_e.func3;
            lsq.ld_pd            <= w_ld_e.pd;
            lsq.ld_rob_tag       <= w_ld_e.rob_tag;
            r_q[w_ld_idx].issued <= 1'b1;
         end
         if (lsq.flush) begin
            for (int i = 0; i < DEPTH; i++)
               if (!w_keep[i]) r_q[i].valid <= 1'b0;
            r_tail <= r_head + w_ncommit;
         end else begin
            if (w_alloc) begin
               r_q[r_tail[IW-1:0]] <= w_new;
               r_tail              <= r_tail + PW'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
               if (lsq.addr_valid && r_q[i].valid
                   && r_q[i].rob_tag == lsq.addr_rob_tag) begin
                  r_q[i].addr     <= lsq.addr;
                  r_q[i].data     <= lsq.addr_st_data;
                  r_q[i].addr_rdy <= 1'b1;
               end
               if (lsq.commit_valid && r_q[i].valid && r_q[i].is_store
                   && r_q[i].rob_tag == lsq.commit_rob_tag)
                  r_q[i].committed <= 1'b1;
            end
         end
         if (w_pop) begin
            r_q[r_head[IW-1:0]].valid <= 1'b0;
            r_head                    <= r_head + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue with store/load scoreboards
// checked whenever the queue pulses store_wb or load_mem.
module tb_load_store_queue;
   import load_store_queue_pkg::*;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic        sh;
   } st_t;

   typedef struct packed {
      logic [31:0] a;
      logic [2:0]  f3;
      logic [6:0]  pd;
      logic [4:0]  tag;
   } ld_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   st_t  exp_st[$];
   ld_t  exp_ld[$];

   load_store_queue_if #(.DEPTH(8)) bus ();

   load_store_queue #(.DEPTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .lsq     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_alloc(input logic st, input logic [2:0] f3,
                           input logic [4:0] tag, input logic [6:0] pd);
      bus.alloc_valid   = 1'b1;
      bus.alloc_store   = st;
      bus.alloc_func3   = f3;
      bus.alloc_rob_tag = tag;
      bus.alloc_pd      = pd;
      tick();
      bus.alloc_valid   = 1'b0;
   endtask

   task automatic do_addr(input logic [4:0] tag, input logic [31:0] a, input logic [31:0] d);
      bus.addr_valid   = 1'b1;
      bus.addr_rob_tag = tag;
      bus.addr         = a;
      bus.addr_st_data = d;
      tick();
      bus.addr_valid   = 1'b0;
   endtask

   task automatic do_commit(input logic [4:0] tag);
      bus.commit_valid   = 1'b1;
      bus.commit_rob_tag = tag;
      tick();
      bus.commit_valid   = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.store_wb && bus.load_mem) chk("wb_ld_excl", 1, 0);
         if (bus.store_wb) begin
            if (exp_st.size() == 0) chk("st_unexpected", 1, 0);
            else chk("st_event", {bus.st_addr, bus.st_data, bus.st_sw_sh},
                     exp_st.pop_front());
         end
         if (bus.load_mem) begin
            if (exp_ld.size() == 0) chk("ld_unexpected", 1, 0);
            else chk("ld_event", {bus.ld_addr, bus.ld_func3, bus.ld_pd, bus.ld_rob_tag},
                     exp_ld.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] d;
      bus.alloc_valid    = 1'b0;
      bus.alloc_store    = 1'b0;
      bus.alloc_func3    = '0;
      bus.alloc_rob_tag  = '0;
      bus.alloc_pd       = '0;
      bus.addr_valid     = 1'b0;
      bus.addr_rob_tag   = '0;
      bus.addr           = '0;
      bus.addr_st_data   = '0;
      bus.commit_valid   = 1'b0;
      bus.commit_rob_tag = '0;
      bus.flush          = 1'b0;
      idle(2);
      chk("rst_count", bus.count, 0);
      chk("rst_store_wb", bus.store_wb, 0);
      chk("rst_load_mem", bus.load_mem, 0);
      reset_n = 1'b1;
      tick();
      chk("rst_ready", bus.alloc_ready, 1);

      for (int i = 0; i < 8; i++) do_alloc(1'b0, F3_LBU, 5'(i), 7'(10 + i));
      chk("full_ready", bus.alloc_ready, 0);
      chk("full_count", bus.count, 8);
      do_alloc(1'b0, F3_LBU, 5'd9, 7'd30);
      chk("full_ignore", bus.count, 8);
      reset_n = 1'b0;
      #2;
      chk("arst_count", bus.count, 0);
      chk("arst_load_mem", bus.load_mem, 0);
      reset_n = 1'b1;
      tick();
      chk("arst_ready", bus.alloc_ready, 1);

      do_alloc(1'b1, F3_SW, 5'd1, 7'd0);
      do_alloc(1'b0, F3_LBU, 5'd2, 7'd20);
      do_addr(5'd2, 32'h200, 32'h0);
      idle(3);
      chk("unk_blk_count", bus.count, 2);
      exp_ld.push_back('{a: 32'h200, f3: F3_LBU, pd: 7'd20, tag: 5'd2});
      do_addr(5'd1, 32'h104, 32'hDEAD0001);
      tick();
      chk("ld_latency", bus.load_mem, 1);
      exp_st.push_back('{a: 32'h104, d: 32'hDEAD0001, sh: 1'b0});
      do_commit(5'd1);
      tick();
      chk("st_latency", bus.store_wb, 1);
      idle(2);
      chk("seq1_count", bus.count, 0);

      do_alloc(1'b1, F3_SW, 5'd3, 7'd0);
      do_alloc(1'b0, F3_LBU, 5'd4, 7'd21);
      do_addr(5'd4, 32'h102, 32'h0);
      do_addr(5'd3, 32'h100, 32'hAAAA5555);
      idle(3);
      chk("ovl_blk_count", bus.count, 2);
      exp_st.push_back('{a: 32'h100, d: 32'hAAAA5555, sh: 1'b0});
      exp_ld.push_back('{a: 32'h102, f3: F3_LBU, pd: 7'd21, tag: 5'd4});
      do_commit(5'd3);
      tick();
      chk("ovl_store_wb", bus.store_wb, 1);
      chk("ovl_no_load", bus.load_mem, 0);
      tick();
      chk("ovl_load_after", bus.load_mem, 1);
      idle(2);
      chk("seq2_count", bus.count, 0);

      do_alloc(1'b1, F3_SH, 5'd5, 7'd0);
      do_alloc(1'b0, F3_LBU, 5'd6, 7'd22);
      do_addr(5'd5, 32'h400, 32'h1234);
      exp_st.push_back('{a: 32'h400, d: 32'h1234, sh: 1'b1});
      exp_ld.push_back('{a: 32'h300, f3: F3_LBU, pd: 7'd22, tag: 5'd6});
      bus.addr_valid     = 1'b1;
      bus.addr_rob_tag   = 5'd6;
      bus.addr           = 32'h300;
      bus.addr_st_data   = 32'h0;
      bus.commit_valid   = 1'b1;
      bus.commit_rob_tag = 5'd5;
      tick();
      bus.addr_valid     = 1'b0;
      bus.commit_valid   = 1'b0;
      tick();
      chk("prio_store_wb", bus.store_wb, 1);
      chk("prio_load_held", bus.load_mem, 0);
      tick();
      chk("prio_load_next", bus.load_mem, 1);
      chk("prio_sw_sh", bus.st_sw_sh, 1);
      idle(2);
      chk("seq3_count", bus.count, 0);

      do_alloc(1'b1, F3_SW, 5'd7, 7'd0);
      do_alloc(1'b1, F3_SW, 5'd8, 7'd0);
      do_alloc(1'b0, F3_LBU, 5'd9, 7'd23);
      do_addr(5'd8, 32'h600, 32'h1);
      do_addr(5'd9, 32'h700, 32'h0);
      do_commit(5'd7);
      chk("pre_flush_count", bus.count, 3);
      bus.flush         = 1'b1;
      bus.alloc_valid   = 1'b1;
      bus.alloc_store   = 1'b0;
      bus.alloc_rob_tag = 5'd15;
      tick();
      bus.flush         = 1'b0;
      bus.alloc_valid   = 1'b0;
      chk("flush_count", bus.count, 1);
      exp_st.push_back('{a: 32'h500, d: 32'h55, sh: 1'b0});
      do_addr(5'd7, 32'h500, 32'h55);
      tick();
      chk("flush_st_wb", bus.store_wb, 1);
      idle(2);
      chk("seq4_count", bus.count, 0);

      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) begin
            d = $urandom;
            do_alloc(1'b1, F3_SW, 5'(10 + i), 7'd0);
            exp_st.push_back('{a: 32'h1000 + 32'(4 * i), d: d, sh: 1'b0});
            do_addr(5'(10 + i), 32'h1000 + 32'(4 * i), d);
            do_commit(5'(10 + i));
         end else begin
            do_alloc(1'b0, F3_LBU, 5'(10 + i), 7'(i));
            exp_ld.push_back('{a: 32'h2000 + 32'(4 * i), f3: F3_LBU, pd: 7'(i),
                               tag: 5'(10 + i)});
            do_addr(5'(10 + i), 32'h2000 + 32'(4 * i), 32'h0);
         end
         idle(2);
      end
      chk("wrap_count", bus.count, 0);
      chk("st_left", exp_st.size(), 0);
      chk("ld_left", exp_ld.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
